capture_replay: RTL and testbench
=================================

# capture_replay

Burst recorder and player for the mic sample path. On `start` it writes a fixed number of mic samples into an internal buffer at the sample-strobe rate. On `play` it streams them back out over a valid/ready interface at up to one sample per clock, once or looped. It is the read-out counterpart of the delay line: that block turns a live stream into a RAM image, and this one turns a captured RAM image back into a stream for the display/DAC side.

## Interface
- `A_WIDTH`, default 9: buffer address width; depth = 2^A_WIDTH samples.
- `D_WIDTH`, default 8: sample width.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  sample strobe; one mic sample per cycle in which `en`=1.
- `start`  in  1  begin capture (pulse).
- `len`  in  A_WIDTH  capture length in samples, latched at `start`; 0 means 2^A_WIDTH.
- `mic_signal`  in  D_WIDTH  input sample, valid when `en`=1.
- `play`  in  1  begin replay (pulse).
- `loop`  in  1  level; sampled at the final accepted sample of each pass.
- `abort`  in  1  return to IDLE from any state (pulse).
- `out_data`  out  D_WIDTH  replay sample.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts when `out_valid` and `out_ready` are both 1.
- `busy`  out  1  high in CAPTURE or PLAY.
- `done`  out  1  high in READY, meaning a complete capture is held.
- `count`  out  A_WIDTH+1  samples written in the current or last capture.

## Operation
- Internal single-clock RAM, 2^A_WIDTH x D_WIDTH. Write is synchronous. Read is synchronous with 1-cycle latency. Write and read never both occur in the same state.
- FSM states: IDLE, CAPTURE, READY, PLAY.
- IDLE:
  - `start` -> CAPTURE. Latch `len` as L (L = 2^A_WIDTH if `len`=0). Clear write address and `count`.
  - `play`, `en` and `out_ready` are ignored.
- CAPTURE:
  - Each `en`=1 cycle writes `mic_signal` at the write address. Write address +1; `count` +1.
  - The cycle that writes sample L-1 also moves the FSM to READY.
  - `start` and `play` are ignored.
- READY:
  - `play` -> PLAY with read address 0.
  - `start` -> CAPTURE; the old data is overwritten.
  - If `start` and `play` arrive together, `start` wins.
- PLAY:
  - Streams samples 0..L-1 in order.
  - After sample L-1 is accepted: if `loop`=1, restart at address 0 with no bubble; otherwise go to READY.
  - `start` and `play` are ignored.
- `abort` in any state -> IDLE next edge. It takes priority over every other input. `out_valid` drops, `done` drops, `count` is held.
- Address arithmetic is modulo 2^A_WIDTH. The end-of-pass comparison uses the (A_WIDTH+1)-bit sample index against L, so full-depth captures terminate correctly.

## Timing
- Reset values: state IDLE, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `count`=0, internal addresses 0. RAM contents are undefined.
- `busy` and `done` are registered and decode the state of the current cycle.
- `start` sampled at edge k: CAPTURE from k. The first `en` is honoured in the cycle after edge k.
- Capture ends at the edge that writes sample L-1; `done`=1 from that edge.
- `play` sampled at edge k: `out_valid` first rises at edge k+2, carrying sample 0.
- With `out_ready` held at 1, one sample is transferred per cycle with no bubbles, including across the loop wrap.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` are held stable. The stall does not drop or repeat any sample; read-ahead is buffered internally.
- Last-pass exit: `out_valid` is 0 in the cycle after the final handshake, and `done`=1 from the same edge.
- Asynchronous reset asserted mid-capture or mid-replay forces the reset values immediately; no partial transfer completes.

## Test plan
- Reset, then `start` with `len`=4 and `en`=1 for 4 cycles with samples 0x10,0x20,0x30,0x40 -> `done`=1 after the 4th write, `count`=4. Then `play` with `out_ready`=1 -> 0x10,0x20,0x30,0x40 on 4 consecutive cycles starting 2 cycles after `play`, then `done`=1.
- Same capture; replay with `out_ready` toggling 1,0,0,1,... -> each sample appears exactly once, and `out_data` is stable while stalled.
- `len`=0 with A_WIDTH=4 -> exactly 16 samples captured, `count`=16. Replay returns all 16 and exits.
- `loop`=1 with `len`=3 (samples A,B,C) -> A,B,C,A,B,C back-to-back. Clear `loop` during the second pass -> exit after that pass's C.
- `abort` mid-PLAY -> next cycle `out_valid`=0, `busy`=0, `done`=0, state IDLE. A following `play` is ignored.
- `start`+`play` in READY -> enters CAPTURE and `count` resets. `en` pulses while in IDLE -> no writes, `count` stays 0.

Source files
------------

// File: rtl/capture_replay.sv
// capture_replay: records a burst of mic samples into an internal RAM and
// streams it back over a valid/ready port, once or looped.
module capture_replay #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic [A_WIDTH-1:0] len,
  input  logic [D_WIDTH-1:0] mic_signal,
  input  logic               play,
  input  logic               loop,
  input  logic               abort,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH:0]   count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2,
    ST_PLAY    = 2'd3
  } state_e;

  localparam int                 DEPTH    = 1 << A_WIDTH;
  localparam logic [A_WIDTH:0]   IDX_ONE  = {{A_WIDTH{1'b0}}, 1'b1};
  localparam logic [A_WIDTH:0]   IDX_ZERO = {(A_WIDTH+1){1'b0}};
  localparam logic [A_WIDTH:0]   FULL_LEN = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [A_WIDTH-1:0] LEN_ZERO = {A_WIDTH{1'b0}};

  state_e               state_q, state_d;
  logic [A_WIDTH:0]     len_q, len_d;
  logic [A_WIDTH:0]     count_q, count_d;
  logic [A_WIDTH:0]     rd_idx_q, rd_idx_d;
  logic [A_WIDTH:0]     acc_idx_q, acc_idx_d;
  logic [1:0]           occ_q, occ_d;
  logic                 pend_q, pend_d;
  logic [D_WIDTH-1:0]   head_q, head_d;
  logic [D_WIDTH-1:0]   skid_q, skid_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [D_WIDTH-1:0]   mem_q [DEPTH];
  logic [D_WIDTH-1:0]   ram_rdata_q;

  logic                 wr_en_s, rd_en_s, pop_s;
  logic                 wr_last_s, acc_last_s;
  logic [1:0]           in_flight_s;
  logic [A_WIDTH:0]     rd_idx_nxt_s, len_sel_s;

  assign pop_s        = out_valid_q & out_ready;
  assign wr_en_s      = (state_q == ST_CAPTURE) & en & ~abort;
  assign in_flight_s  = occ_q + {1'b0, pend_q};
  // Keep at most two samples queued or in flight so a stall never overruns.
  assign rd_en_s      = (state_q == ST_PLAY) &
                        ((in_flight_s < 2'd2) | (pop_s & (in_flight_s == 2'd2)));
  assign rd_idx_nxt_s = rd_idx_q + IDX_ONE;
  assign wr_last_s    = (count_q + IDX_ONE) == len_q;
  assign acc_last_s   = (acc_idx_q + IDX_ONE) == len_q;
  assign len_sel_s    = (len == LEN_ZERO) ? FULL_LEN : {1'b0, len};

  assign out_data  = head_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;

  // Sample buffer: written only while capturing, read only while playing.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_q[count_q[A_WIDTH-1:0]] <= mic_signal;
    if (rd_en_s) ram_rdata_q <= mem_q[rd_idx_q[A_WIDTH-1:0]];
  end

  // Next-state logic, address bookkeeping and the two-entry output queue.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    acc_idx_d = acc_idx_q;
    occ_d     = occ_q;
    pend_d    = rd_en_s;
    head_d    = head_q;
    skid_d    = skid_q;

    if (rd_en_s) begin
      rd_idx_d = (rd_idx_nxt_s == len_q) ? IDX_ZERO : rd_idx_nxt_s;
    end else begin
      rd_idx_d = rd_idx_q;
    end

    case ({pop_s, pend_q})
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = skid_q;
          skid_d = ram_rdata_q;
        end else begin
          head_d = ram_rdata_q;
          occ_d  = 2'd1;
        end
      end
      2'b10: begin
        if (occ_q == 2'd2) begin
          head_d = skid_q;
          occ_d  = 2'd1;
        end else begin
          occ_d  = 2'd0;
        end
      end
      2'b01: begin
        if (occ_q == 2'd0) begin
          head_d = ram_rdata_q;
          occ_d  = 2'd1;
        end else begin
          skid_d = ram_rdata_q;
          occ_d  = 2'd2;
        end
      end
      default: occ_d = occ_q;
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      occ_d     = 2'd0;
      pend_d    = 1'b0;
      rd_idx_d  = IDX_ZERO;
      acc_idx_d = IDX_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_CAPTURE;
            len_d   = len_sel_s;
            count_d = IDX_ZERO;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          if (en) begin
            count_d = count_q + IDX_ONE;
            state_d = wr_last_s ? ST_READY : ST_CAPTURE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
        ST_READY: begin
          if (start) begin
            state_d = ST_CAPTURE;
            len_d   = len_sel_s;
            count_d = IDX_ZERO;
          end else if (play) begin
            state_d   = ST_PLAY;
            rd_idx_d  = IDX_ZERO;
            acc_idx_d = IDX_ZERO;
            occ_d     = 2'd0;
            pend_d    = 1'b0;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_PLAY: begin
          if (pop_s && acc_last_s) begin
            acc_idx_d = IDX_ZERO;
            if (!loop) begin
              // Read-ahead from the next pass is discarded on exit.
              state_d  = ST_READY;
              occ_d    = 2'd0;
              pend_d   = 1'b0;
              rd_idx_d = IDX_ZERO;
            end else begin
              state_d = ST_PLAY;
            end
          end else if (pop_s) begin
            acc_idx_d = acc_idx_q + IDX_ONE;
          end else begin
            acc_idx_d = acc_idx_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    out_valid_d = (occ_d != 2'd0);
    busy_d      = (state_d == ST_CAPTURE) || (state_d == ST_PLAY);
    done_d      = (state_d == ST_READY);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      len_q       <= FULL_LEN;
      count_q     <= IDX_ZERO;
      rd_idx_q    <= IDX_ZERO;
      acc_idx_q   <= IDX_ZERO;
      occ_q       <= 2'd0;
      pend_q      <= 1'b0;
      head_q      <= {D_WIDTH{1'b0}};
      skid_q      <= {D_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      rd_idx_q    <= rd_idx_d;
      acc_idx_q   <= acc_idx_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_capture_replay.sv
// tb_capture_replay: directed and randomized capture/replay checks against a
// sample-list model of the captured burst.
module tb_capture_replay;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, start = 1'b0, play = 1'b0, loop = 1'b0, abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] len = 4'd0;
  logic [DW-1:0] mic_signal = 8'd0;
  logic [DW-1:0] out_data;
  logic          out_valid, busy, done;
  logic [AW:0]   count;

  int compared = 0;
  int mismatched = 0;
  logic [DW-1:0] mbuf [16];
  logic [DW-1:0] pat [16];
  int mlen = 0;

  capture_replay #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .len(len),
    .mic_signal(mic_signal), .play(play), .loop(loop), .abort(abort),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture a burst; the model records every sample offered with en=1.
  task automatic capture(input logic [AW-1:0] lf, input bit use_pat, input bit gaps,
                         input bit with_play);
    int wr = 0;
    int cyc = 0;
    logic e;
    logic [DW-1:0] d;
    mlen = (lf == 4'd0) ? 16 : int'(lf);
    start = 1'b1; play = with_play; len = lf;
    step();
    start = 1'b0; play = 1'b0;
    chk("cap_enter_busy", 32'(busy), 32'd1);
    chk("cap_enter_done", 32'(done), 32'd0);
    chk("cap_count_clr", 32'(count), 32'd0);
    while (wr < mlen && cyc < 400) begin
      e = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d = use_pat ? pat[wr] : 8'($urandom_range(0, 255));
      en = e; mic_signal = d;
      step();
      en = 1'b0; cyc++;
      if (e) begin
        mbuf[wr] = d;
        wr++;
      end
      chk("cap_count", 32'(count), 32'(wr));
      chk("cap_done", 32'(done), 32'(wr == mlen));
    end
    chk("cap_end_busy", 32'(busy), 32'd0);
  endtask

  // Replay 'passes' passes; mode 0: ready=1, 1: pattern 1,0,0,1, else random.
  task automatic run_play(input int mode, input int passes);
    int got = 0;
    int cyc = 0;
    int first_v = -1;
    int bubbles = 0;
    int n_exp;
    bit prev_stall = 1'b0;
    bit rdy;
    n_exp = passes * mlen;
    out_ready = 1'b0;
    play = 1'b1;
    step();
    play = 1'b0;
    chk("play_busy", 32'(busy), 32'd1);
    chk("play_done_low", 32'(done), 32'd0);
    while (got < n_exp && cyc < 1000) begin
      loop = ((got / mlen) < passes - 1);
      if (out_valid && first_v < 0) first_v = cyc;
      if (!out_valid && first_v >= 0) bubbles++;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(mbuf[got % mlen]));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (out_valid && rdy) begin
        chk("play_data", 32'(out_data), 32'(mbuf[got % mlen]));
        got++;
      end
      prev_stall = out_valid && !rdy;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    loop = 1'b0;
    chk("play_complete", 32'(got), 32'(n_exp));
    chk("first_valid_lat", 32'(first_v), 32'd2);
    if (mode == 0) chk("no_bubble", 32'(bubbles), 32'd0);
    chk("exit_valid", 32'(out_valid), 32'd0);
    chk("exit_done", 32'(done), 32'd1);
    chk("exit_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #3;
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    step(); step();
    rst = 1'b1;
    step();

    // en/play/out_ready in IDLE are ignored
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; play = 1'b1; out_ready = 1'b1; mic_signal = 8'(i + 1);
      step();
    end
    en = 1'b0; play = 1'b0; out_ready = 1'b0;
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // basic four-sample burst, replayed free-running and with stalls
    pat[0] = 8'h10; pat[1] = 8'h20; pat[2] = 8'h30; pat[3] = 8'h40;
    capture(4'd4, 1'b1, 1'b0, 1'b0);
    chk("cap4_count", 32'(count), 32'd4);
    run_play(0, 1);
    run_play(1, 1);

    // len=0 means full depth
    capture(4'd0, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd16);
    run_play(0, 1);

    // looped replay, loop cleared during the second pass
    pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3;
    capture(4'd3, 1'b1, 1'b0, 1'b0);
    run_play(0, 2);
    run_play(1, 3);

    // abort mid-replay, then a play from IDLE is ignored
    out_ready = 1'b1; play = 1'b1;
    step();
    play = 1'b0;
    step(); step(); step();
    chk("pre_abort_valid", 32'(out_valid), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_count", 32'(count), 32'd3);
    play = 1'b1;
    step();
    play = 1'b0;
    step(); step(); step();
    chk("post_abort_valid", 32'(out_valid), 32'd0);
    chk("post_abort_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;

    // start and play together in READY: start wins
    capture(4'd2, 1'b0, 1'b0, 1'b0);
    capture(4'd5, 1'b0, 1'b0, 1'b1);
    run_play(2, 1);

    // randomized lengths, en gaps, ready patterns and pass counts
    for (int k = 0; k < 6; k++) begin
      capture(4'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0);
      run_play(2, int'($urandom_range(1, 2)));
    end

    // asynchronous reset mid-replay
    out_ready = 1'b1; play = 1'b1;
    step();
    play = 1'b0;
    step(); step(); step();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    #3;
    rst = 1'b1;
    step(); step();
    chk("arst_idle_valid", 32'(out_valid), 32'd0);
    chk("arst_idle_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
